// File: rtl/id_char_tx.sv
// id_char_tx: serialises a loaded identifier string one character per clock
// and drives alongside each character the verdict an identifier recogniser
// is expected to give for it (letter followed by one or more digits).
module id_char_tx #(
    parameter int          MAX_LEN   = 8,
    parameter logic [7:0]  IDLE_CHAR = 8'd32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           load_valid,
    output logic                           load_ready,
    input  logic [8*MAX_LEN-1:0]           load_data,
    input  logic [$clog2(MAX_LEN+1)-1:0]   load_len,
    output logic [7:0]                     char,
    output logic                           char_valid,
    output logic                           match,
    output logic                           busy,
    output logic                           done
);

    localparam int LW = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
    typedef enum logic [1:0] {T_START, T_LET, T_DIG, T_ERR} trk_t;
    typedef enum logic [1:0] {C_L, C_D, C_O} cls_t;

    state_t               state;
    trk_t                 trk;
    logic [LW-1:0]        index;
    logic [LW-1:0]        len_q;
    logic [8*MAX_LEN-1:0] buf_q;
    logic [7:0]           next_char;
    logic [LW-1:0]        len_eff;
    trk_t                 trk_load;
    trk_t                 trk_send;

    // Unsigned byte compares only; anything outside the two ranges, including
    // codes >= 128, is "other".
    function automatic cls_t classify(input logic [7:0] c);
        if ((c >= 8'd65 && c <= 8'd90) || (c >= 8'd97 && c <= 8'd122))
            return C_L;
        else if (c >= 8'd48 && c <= 8'd57)
            return C_D;
        else
            return C_O;
    endfunction

    function automatic trk_t trk_next(input trk_t t, input logic [7:0] c);
        cls_t cl;
        cl = classify(c);
        case (t)
            T_START: return (cl == C_L) ? T_LET : T_ERR;
            T_LET:   return (cl == C_L) ? T_LET : ((cl == C_D) ? T_DIG : T_ERR);
            T_DIG:   return (cl == C_D) ? T_DIG : T_ERR;
            default: return T_ERR;
        endcase
    endfunction

    // Requested lengths beyond the buffer are clamped to the buffer size.
    function automatic logic [LW-1:0] sat_len(input logic [LW-1:0] n);
        if (n > LW'(MAX_LEN))
            return LW'(MAX_LEN);
        else
            return n;
    endfunction

    assign load_ready = (state == IDLE);
    assign len_eff    = sat_len(load_len);
    assign trk_load   = trk_next(T_START, load_data[7:0]);
    assign trk_send   = trk_next(trk, next_char);

    // Select the buffered character at the current index.
    always_comb begin
        next_char = buf_q[7:0];
        for (int k = 0; k < MAX_LEN; k++) begin
            if (index == LW'(k))
                next_char = buf_q[8*k +: 8];
        end
    end

    // String buffer: captured only on an accepted load so it is stable mid-string.
    always_ff @(posedge clk) begin
        if (load_valid && load_ready)
            buf_q <= load_data;
    end

    // Control FSM; outputs are registered so the state always names what is on the bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            trk        <= T_START;
            index      <= '0;
            len_q      <= '0;
            char       <= IDLE_CHAR;
            char_valid <= 1'b0;
            match      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    // A zero-length load is consumed without leaving IDLE.
                    if (load_valid && len_eff != '0) begin
                        len_q      <= len_eff;
                        index      <= LW'(1);
                        trk        <= trk_load;
                        match      <= (trk_load == T_DIG);
                        char       <= load_data[7:0];
                        char_valid <= 1'b1;
                        busy       <= 1'b1;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    if (index == len_q) begin
                        char       <= IDLE_CHAR;
                        char_valid <= 1'b0;
                        match      <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= GAP;
                    end else begin
                        char  <= next_char;
                        trk   <= trk_send;
                        match <= (trk_send == T_DIG);
                        index <= index + LW'(1);
                    end
                end
                GAP: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_id_char_tx.sv
// Directed bench for id_char_tx: table of strings with hand-computed match
// masks, plus sequences for zero-length, held load_valid and mid-string reset.
module tb_id_char_tx;

    localparam int MAX_LEN = 8;

    logic        clk;
    logic        reset;
    logic        load_valid;
    logic        load_ready;
    logic [63:0] load_data;
    logic [3:0]  load_len;
    logic [7:0]  char;
    logic        char_valid;
    logic        match;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    id_char_tx #(.MAX_LEN(MAX_LEN), .IDLE_CHAR(8'd32)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_len   (load_len),
        .char       (char),
        .char_valid (char_valid),
        .match      (match),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [63:0] data;
        logic [3:0]  len;
        int          n;
        logic [7:0]  mask;
    } vec_t;

    vec_t vt[16];

    function automatic logic [63:0] pack(input string s);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < s.len() && i < 8; i++)
            r[8*i +: 8] = s[i];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input string nm, input logic [63:0] d, input logic [3:0] l,
                           input int n, input logic [7:0] m);
        int t;
        t = 0;
        while (load_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk({nm, " ready"}, 32'(load_ready), 1);
        load_data  = d;
        load_len   = l;
        load_valid = 1'b1;
        @(posedge clk);
        #1 load_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk($sformatf("%s char%0d", nm, k), 32'(char), 32'(d[8*k +: 8]));
            chk($sformatf("%s valid%0d", nm, k), 32'(char_valid), 1);
            chk($sformatf("%s busy%0d", nm, k), 32'(busy), 1);
            chk($sformatf("%s match%0d", nm, k), 32'(match), 32'(m[k]));
            chk($sformatf("%s nodone%0d", nm, k), 32'(done), 0);
        end
        @(negedge clk);
        chk({nm, " gap char"}, 32'(char), 32);
        chk({nm, " gap valid"}, 32'(char_valid), 0);
        chk({nm, " gap done"}, 32'(done), 1);
        chk({nm, " gap ready"}, 32'(load_ready), 0);
        chk({nm, " gap busy"}, 32'(busy), 0);
        @(negedge clk);
        chk({nm, " idle ready"}, 32'(load_ready), 1);
        chk({nm, " idle done"}, 32'(done), 0);
    endtask

    initial begin
        vt[0]  = '{"a1",       pack("a1"),         4'd2,  2, 8'h02};
        vt[1]  = '{"ab12",     pack("ab12"),       4'd4,  4, 8'h0C};
        vt[2]  = '{"1a",       pack("1a"),         4'd2,  2, 8'h00};
        vt[3]  = '{"a1b2",     pack("a1b2"),       4'd4,  4, 8'h02};
        vt[4]  = '{"len12",    pack("abcdefgh"),   4'd12, 8, 8'h00};
        vt[5]  = '{"z9999999", pack("z9999999"),   4'd8,  8, 8'hFE};
        vt[6]  = '{"x",        pack("x"),          4'd1,  1, 8'h00};
        vt[7]  = '{"Zz0",      pack("Zz0"),        4'd3,  3, 8'h04};
        vt[8]  = '{"AZaz09",   pack("AZaz09"),     4'd6,  6, 8'h30};
        vt[9]  = '{"@1",       pack("@1"),         4'd2,  2, 8'h00};
        vt[10] = '{"[1",       pack("[1"),         4'd2,  2, 8'h00};
        vt[11] = '{"`1",       pack("`1"),         4'd2,  2, 8'h00};
        vt[12] = '{"{1",       pack("{1"),         4'd2,  2, 8'h00};
        vt[13] = '{"a/",       pack("a/"),         4'd2,  2, 8'h00};
        vt[14] = '{"a:",       pack("a:"),         4'd2,  2, 8'h00};
        vt[15] = '{"hi-code",  64'h0000_0000_0031_C161, 4'd3, 3, 8'h00};

        reset      = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        load_len   = '0;
        #12;
        chk("rst char", 32'(char), 32);
        chk("rst valid", 32'(char_valid), 0);
        chk("rst match", 32'(match), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst done", 32'(done), 0);
        chk("rst ready", 32'(load_ready), 1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 16; i++)
            run_vec(vt[i].name, vt[i].data, vt[i].len, vt[i].n, vt[i].mask);

        // Zero-length load: consumed silently.
        load_data  = pack("ab");
        load_len   = 4'd0;
        load_valid = 1'b1;
        @(posedge clk);
        #1 load_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("len0 valid%0d", k), 32'(char_valid), 0);
            chk($sformatf("len0 done%0d", k), 32'(done), 0);
            chk($sformatf("len0 ready%0d", k), 32'(load_ready), 1);
        end

        // load_valid held with changing data across SEND and GAP.
        load_data  = pack("ab");
        load_len   = 4'd2;
        load_valid = 1'b1;
        @(posedge clk);
        #1 load_data = pack("xy");
        @(negedge clk);
        chk("hold c1", 32'(char), 32'h61);
        @(negedge clk);
        chk("hold c2", 32'(char), 32'h62);
        @(negedge clk);
        chk("hold gap done", 32'(done), 1);
        chk("hold gap char", 32'(char), 32);
        chk("hold gap ready", 32'(load_ready), 0);
        @(negedge clk);
        chk("hold sep valid", 32'(char_valid), 0);
        chk("hold sep ready", 32'(load_ready), 1);
        @(negedge clk);
        chk("hold c3", 32'(char), 32'h78);
        chk("hold c3 valid", 32'(char_valid), 1);
        load_valid = 1'b0;
        @(negedge clk);
        chk("hold c4", 32'(char), 32'h79);
        @(negedge clk);
        chk("hold gap2 done", 32'(done), 1);
        @(negedge clk);

        // Asynchronous reset in the middle of a string.
        load_data  = pack("abcd");
        load_len   = 4'd4;
        load_valid = 1'b1;
        @(posedge clk);
        #1 load_valid = 1'b0;
        @(negedge clk);
        chk("arst c1", 32'(char), 32'h61);
        @(negedge clk);
        chk("arst c2", 32'(char), 32'h62);
        #2 reset = 1'b1;
        #1;
        chk("arst char", 32'(char), 32);
        chk("arst valid", 32'(char_valid), 0);
        chk("arst busy", 32'(busy), 0);
        chk("arst done", 32'(done), 0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("arst nodone%0d", k), 32'(done), 0);
            chk($sformatf("arst novalid%0d", k), 32'(char_valid), 0);
        end
        run_vec("post-rst ab12", pack("ab12"), 4'd4, 4, 8'h0C);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/id_char_tx.md
Name: id_char_tx

Overview:
- Transmitter side of the identifier character stream. It accepts a packed string of up to MAX_LEN ASCII characters over a valid/ready load handshake. It then drives the characters out one per clock on an 8-bit char bus, which is the same stream format the identifier recogniser consumes.
- In parallel it drives match: the expected recogniser verdict for each emitted character. This lets the block act both as the stimulus source and as the scoreboard reference for the recogniser.

Parameters:
- MAX_LEN, 8, maximum characters per load (≥1).
- IDLE_CHAR, 8'd32, separator character driven whenever no string character is being sent (ASCII space).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- load_valid  input  1  load request
- load_ready  output  1  block can accept a load
- load_data  input  8*MAX_LEN  packed string; char k in bits [8k+7:8k], char 0 sent first
- load_len  input  $clog2(MAX_LEN+1)  number of characters to send
- char  output  8  current character (registered)
- char_valid  output  1  char is a string character (not separator)
- match  output  1  expected recogniser output for the current char (registered with char)
- busy  output  1  string transfer in progress
- done  output  1  one-cycle pulse on the separator cycle after the last character

Behaviour:
- Reset values (asynchronous, immediate):
  - state=IDLE
  - char=IDLE_CHAR, char_valid=0, match=0, busy=0, done=0
  - index=0, class tracker=T_START
- States: IDLE, SEND, GAP.
- IDLE:
  - load_ready=1, char=IDLE_CHAR, char_valid=0, match=0.
  - Load fires on a clk edge with load_valid&&load_ready.
  - load_data is captured into an internal buffer. len_eff = min(load_len, MAX_LEN).
  - If len_eff==0: load is consumed, no output, remain IDLE.
  - Otherwise: index=0, tracker=T_START, go to SEND.
  - First char appears on the edge after acceptance (1-cycle latency).
- SEND:
  - load_ready=0, busy=1.
  - Each cycle the char register = buffer[index], char_valid=1, index increments.
  - After index len_eff-1 is presented, go to GAP.
  - load_valid is ignored while not in IDLE; the buffer must not change mid-string.
- GAP (exactly 1 cycle):
  - char=IDLE_CHAR, char_valid=0, match=0, done=1, busy=0.
  - Next state is IDLE.
  - load_ready stays 0 in GAP, so back-to-back strings are always separated by ≥1 separator cycle.
- Class tracker (updated per emitted char, reset at each load):
  - Character classes:
    - L = 'A'..'Z' or 'a'..'z'
    - D = '0'..'9'
    - O = anything else
  - Transitions:
    - T_START: L→T_LET, D/O→T_ERR.
    - T_LET: L→T_LET, D→T_DIG, O→T_ERR.
    - T_DIG: D→T_DIG, L/O→T_ERR.
    - T_ERR: absorbing until next load.
  - match = 1 iff the next tracker state is T_DIG. Tracker state and match are registered on the same edge as char, so match refers to the char presented in the same cycle.
- Class decode uses unsigned 8-bit compares only. Codes ≥128 are O.
- Reset asserted mid-SEND: output returns immediately to reset values, the string is abandoned, and no done pulse is produced.
- done and char_valid are never high in the same cycle. busy==char_valid at all times.

Test Plan:
- Reset then load "a1" (len 2): chars 97,49 with match 0,1 on consecutive cycles. Next cycle char=32, done=1. load_ready returns 1 the cycle after.
- Load "ab12" (len 4): char 97,98,49,50 / match 0,0,1,1. Exactly 4 cycles of char_valid, then one done pulse.
- Load "1a" (len 2): match 0,0 (T_ERR absorbing). Load "a1b2": match 0,1,0,0.
- Load len 0 with load_valid=1: no char_valid, no done, load_ready stays 1. Load len 12 with MAX_LEN=8: exactly 8 chars emitted.
- Hold load_valid high with new data during SEND and GAP: ignored; the second load is accepted only in IDLE, and ≥1 separator cycle appears between strings.
- Assert reset asynchronously mid-SEND of "abcd" after 2 chars: char=32, char_valid=0, busy=0 immediately. No done pulse; the next load behaves normally.
